mem_access_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the 16-entry memory.
- Accepts write/read transactions over a valid/ready request interface and buffers them in an in-order FIFO.
- Drives the memory's separate write port (wr_en/addrw/wdata) and read port (rd_en/addrr), then captures rdata after a fixed read latency.
- Returns each read result on a valid/ready response interface; writes produce no response.

---
 rtl/mem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Request front-end for a small memory that has separate write and read ports.
// Write/read requests arrive on a valid/ready interface and go into an in-order
// FIFO. An FSM drains the FIFO and drives the memory strobes. Read data is
// captured after a fixed latency and returned on a valid/ready response
// interface. Writes produce no response.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clk
// edge where valid && ready are both high. The producer holds valid and the
// payload stable until the transfer. Ready may be low at any time.
//
// Optional build feature (macro MEM_CTRL_CHECK_EN):
//   defined   - a shadow copy of every write is kept, together with a valid bit
//               per address. err_flag pulses when a read returns data that
//               differs from the shadow copy of an address already written.
//   undefined - no shadow storage is built and err_flag stays 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr/req_wdata      request address / write data
//   rsp_valid/rsp_ready     read-response handshake
//   rsp_addr/rsp_rdata      address and data of the returned read
//   wr_en/addrw/wdata       memory write port (registered)
//   rd_en/addrr             memory read port (registered)
//   rdata                   memory read data, valid RD_LAT cycles after rd_en
//   err_flag                data-check error pulse
//   dbg_state               current FSM state encoding
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addrw,
    output logic [DATA_W-1:0] wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addrr,
    input  logic [DATA_W-1:0] rdata,
    output logic              err_flag,
    output logic [2:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic              fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic              push;
    logic              pop;
    logic              empty;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign push       = req_valid && req_ready;
    assign empty      = (count == '0);
    assign head_write = fifo_write[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_data[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + FCNT_ONE;
        end else if (!push && pop) begin
            count_next = count - FCNT_ONE;
        end
    end

    // Storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_data[wr_ptr]  <= req_wdata;
        end
    end

    // req_ready is registered from the next count, so it always equals
    // (count < FIFO_DEPTH) of the current cycle but is 0 while in reset.
    // Since pop is only known from the registered count, an entry pushed
    // at one edge cannot be popped before the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count     <= count_next;
            req_ready <= (count_next < FIFO_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Optional data check against a shadow copy of written data
    // ------------------------------------------------------------------
    logic check_err;

`ifdef MEM_CTRL_CHECK_EN
    logic [DATA_W-1:0]      shadow_mem [2**ADDR_W];
    logic [2**ADDR_W-1:0]   shadow_vld;

    always_ff @(posedge clk) begin
        if (wr_en) shadow_mem[addrw] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_vld <= '0;
        end else if (wr_en) begin
            shadow_vld[addrw] <= 1'b1;
        end
    end

    // addrr still holds the address of the outstanding read at capture time.
    assign check_err = shadow_vld[addrr] && (rdata != shadow_mem[addrr]);
`else
    assign check_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] wait_cnt;
    logic             capture;

    assign capture   = (state == WAIT) && (wait_cnt == WAIT_ONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head_write ? WRITE : READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_ONE) state_next = RESP;
            end
            RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone
                // completes the handshake.
                if (rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = head_write ? WRITE : READ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered memory strobes and response path
    // ------------------------------------------------------------------
    // The strobes are loaded at the pop edge, so each one is high exactly
    // for the WRITE or READ cycle that follows. They are mutually exclusive
    // because a pop is either a write or a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            addrw     <= '0;
            wdata     <= '0;
            rd_en     <= 1'b0;
            addrr     <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
            err_flag  <= 1'b0;
        end else begin
            wr_en <= pop && head_write;
            rd_en <= pop && !head_write;
            if (pop && head_write) begin
                addrw <= head_addr;
                wdata <= head_wdata;
            end
            if (pop && !head_write) begin
                addrr <= head_addr;
            end

            if (state == READ) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WAIT_ONE;
            end

            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= addrr;
                rsp_rdata <= rdata;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // Set at the capture edge so it coincides with the first
            // cycle of rsp_valid.
            err_flag <= capture && check_err;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RW = AW + DW;

`ifdef MEM_CTRL_CHECK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          wr_en;
    logic [AW-1:0] addrw;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [AW-1:0] addrr;
    logic [DW-1:0] rdata;
    logic          err_flag;
    logic [2:0]    dbg_state;

    mem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .wr_en(wr_en), .addrw(addrw), .wdata(wdata),
        .rd_en(rd_en), .addrr(addrr), .rdata(rdata),
        .err_flag(err_flag), .dbg_state(dbg_state)
    );

    // ---------------- memory model (read latency 1) ----------------
    logic [DW-1:0] mem [16] = '{default: 16'h0000};
    logic [DW-1:0] mem_rd_q = '0;
    logic          force_en = 1'b0;
    logic [DW-1:0] force_val = '0;

    assign rdata = force_en ? force_val : mem_rd_q;

    always @(posedge clk) begin
        if (wr_en) mem[addrw] <= wdata;
        if (rd_en) mem_rd_q <= mem[addrr];
    end

    logic [51:0] all_out;
    assign all_out = {req_ready, rsp_valid, rsp_addr, rsp_rdata, wr_en, addrw,
                      wdata, rd_en, addrr, err_flag, dbg_state};

    // ---------------- scoreboard / monitor ----------------
    int total = 0;
    int bad = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int wr_run = 0;
    int wr_run_last = 0;
    int overlap_cnt = 0;
    int err_cycles = 0;
    int err_orphan = 0;
    int rsp_valid_cycles = 0;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) got_q.push_back({rsp_addr, rsp_rdata});
        if (wr_en) begin
            wr_run = wr_run + 1;
        end else begin
            if (wr_run != 0) wr_run_last = wr_run;
            wr_run = 0;
        end
        if (wr_en && rd_en) overlap_cnt = overlap_cnt + 1;
        if (err_flag) begin
            err_cycles = err_cycles + 1;
            if (!rsp_valid) err_orphan = err_orphan + 1;
        end
        if (rsp_valid) rsp_valid_cycles = rsp_valid_cycles + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL req_accept_timeout: got no req_ready expected accept of addr %0d", a);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (got_q.size() >= exp_q.size()) return;
        end
        total++;
        bad++;
        $display("FAIL rsp_timeout: got %0d responses expected %0d", got_q.size(), exp_q.size());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (all_out !== 52'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read_seq();
        logic [RW-1:0] e, g;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_req(1'b1, AW'(i), DW'(16'h1000 + i));
        for (int i = 0; i < 8; i++) begin
            send_req(1'b0, AW'(i), 16'h0000);
            exp_q.push_back({AW'(i), DW'(16'h1000 + i)});
        end
        req_valid = 1'b0;
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL seq_rsp: got %h expected %h", g, e);
            end
        end
        total++;
        if (wr_run_last !== 8) begin
            bad++;
            $display("FAIL seq_wr_burst: got %0d consecutive wr_en expected 8", wr_run_last);
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] e, g;
        int acc;
        int stable;
        acc = 0;
        stable = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd2;
        req_wdata = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            @(posedge clk);
            #1;
            if (acc == 6) req_valid = 1'b0;
        end
        total++;
        if (acc !== 5) begin
            bad++;
            $display("FAIL bp_accepted: got %0d expected 5", acc);
        end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_req_ready: got %b expected 0", req_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_addr === 4'd2 && rsp_rdata === 16'h1002) stable++;
        end
        total++;
        if (stable !== 20) begin
            bad++;
            $display("FAIL bp_rsp_stable: got %0d stable cycles expected 20", stable);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back({4'd2, 16'h1002});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL bp_rsp: got %h expected %h", g, e);
            end
        end
    endtask

    task automatic test_raw();
        logic [RW-1:0] e, g;
        send_req(1'b1, 4'd3, 16'hA5A5);
        send_req(1'b0, 4'd3, 16'h0000);
        send_req(1'b1, 4'd3, 16'h5A5A);
        send_req(1'b0, 4'd3, 16'h0000);
        req_valid = 1'b0;
        exp_q.push_back({4'd3, 16'hA5A5});
        exp_q.push_back({4'd3, 16'h5A5A});
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL raw_rsp: got %h expected %h", g, e);
            end
        end
    endtask

    task automatic test_addr_bounds();
        logic [RW-1:0] e, g;
        send_req(1'b1, 4'd15, 16'hFFFF);
        send_req(1'b1, 4'd0, 16'h0001);
        send_req(1'b0, 4'd15, 16'h0000);
        send_req(1'b0, 4'd0, 16'h0000);
        req_valid = 1'b0;
        exp_q.push_back({4'd15, 16'hFFFF});
        exp_q.push_back({4'd0, 16'h0001});
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL bounds_rsp: got %h expected %h", g, e);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [RW-1:0] e, g;
        int v0;
        int g0;
        bit seen;
        seen = 1'b0;
        rsp_ready = 1'b1;
        send_req(1'b0, 4'd3, 16'h0000);
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_rd_en_seen: got no rd_en expected one");
        end
        @(posedge clk);
        #2;
        v0 = rsp_valid_cycles;
        g0 = got_q.size();
        rst_n = 1'b0;
        #1;
        total++;
        if (all_out !== 52'h0) begin
            bad++;
            $display("FAIL rst_async_outputs: got %h expected 0", all_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (rsp_valid_cycles !== v0 || got_q.size() !== g0) begin
            bad++;
            $display("FAIL rst_no_rsp: got %0d rsp_valid cycles expected 0",
                     rsp_valid_cycles - v0);
        end
        @(posedge clk);
        #1;
        send_req(1'b1, 4'd5, 16'hBEEF);
        send_req(1'b0, 4'd5, 16'h0000);
        req_valid = 1'b0;
        exp_q.push_back({4'd5, 16'hBEEF});
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL rst_after_rsp: got %h expected %h", g, e);
            end
        end
    endtask

    task automatic test_data_check();
        logic [RW-1:0] e, g;
        int e0;
        bit seen;
        seen = 1'b0;
        send_req(1'b1, 4'd4, 16'h1234);
        rsp_ready = 1'b0;
        force_val = 16'h1235;
        force_en  = 1'b1;
        send_req(1'b0, 4'd4, 16'h0000);
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || err_flag !== CHK_ON) begin
            bad++;
            $display("FAIL chk_err_pulse: got err_flag=%b rsp_valid=%b expected err_flag=%b",
                     err_flag, rsp_valid, CHK_ON);
        end
        total++;
        if (rsp_rdata !== 16'h1235 || rsp_addr !== 4'd4) begin
            bad++;
            $display("FAIL chk_forced_data: got %h/%h expected 4/1235", rsp_addr, rsp_rdata);
        end
        @(negedge clk);
        total++;
        if (err_flag !== 1'b0 || rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL chk_err_width: got err_flag=%b rsp_valid=%b expected 0/1",
                     err_flag, rsp_valid);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        exp_q.push_back({4'd4, 16'h1235});
        wait_rsp();
        force_en = 1'b0;
        e0 = err_cycles;
        send_req(1'b0, 4'd9, 16'h0000);
        req_valid = 1'b0;
        exp_q.push_back({4'd9, 16'h0000});
        wait_rsp();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL chk_rsp: got %h expected %h", g, e);
            end
        end
        total++;
        if (err_cycles !== e0) begin
            bad++;
            $display("FAIL chk_unwritten: got %0d err pulses expected 0", err_cycles - e0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read_seq();
        test_backpressure();
        test_raw();
        test_addr_bounds();
        test_reset_in_flight();
        test_data_check();
        repeat (3) @(negedge clk);
        total++;
        if (overlap_cnt !== 0) begin
            bad++;
            $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt);
        end
        total++;
        if (err_orphan !== 0) begin
            bad++;
            $display("FAIL err_without_rsp: got %0d cycles expected 0", err_orphan);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
